keypad_scan_unit: RTL and testbench
===================================

KEYPAD_SCAN_UNIT -- requirements
Module: keypad_scan_unit

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clk_src cycles per row dwell (>=2).
REQ-002 Parameter DEBOUNCE_CNT, default 4, consecutive matching samples required for press and for release (>=1).
REQ-003 Parameter DATA_WIDTH, default 32, width of key_data; SHALL be a multiple of 4.
REQ-004 clk_src  input  1  sole clock; all state on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 col_n  input  4  keypad columns, active-low, externally pulled up, asynchronous to clk_src.
REQ-007 clear  input  1  synchronous clear of key_data, level-sampled each cycle.
REQ-008 row_n  output  4  row drive, active-low, exactly one bit low at all times.
REQ-009 key_code  output  4  last accepted key, {row[1:0], col[1:0]}.
REQ-010 key_valid  output  1  one-cycle pulse when a key is accepted.
REQ-011 key_held  output  1  high while the accepted key is still held.
REQ-012 key_data  output  DATA_WIDTH  shift register of accepted key codes, newest in [3:0]; directly drivable into the display driver's led_data.

Function
REQ-013 col_n SHALL pass through a two-flop synchronizer before any use.
REQ-014 A free-running counter SHALL assert internal tick for one cycle every SCAN_DIV cycles; synchronized columns are sampled only on tick.
REQ-015 States: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-016 SCAN: on each tick with no valid sample, row index advances 0->1->2->3->0 (row_n 1110->1101->1011->0111->1110).
REQ-017 A valid sample has exactly one col bit low; zero or multiple low bits (ghosting) SHALL be treated as no key.
REQ-018 SCAN, valid sample on tick: latch row/col, count=1, row frozen, go DEBOUNCE (or accept immediately if DEBOUNCE_CNT=1).
REQ-019 DEBOUNCE, tick: same col -> count++; on count reaching DEBOUNCE_CNT accept; any other sample -> SCAN, row advances.
REQ-020 Accept: key_code updated, key_valid pulses the cycle after the accepting tick, key_data <= {key_data[DATA_WIDTH-5:0], code}, key_held=1, go HELD.
REQ-021 HELD, tick: all cols high -> count=1, go RELEASE (or SCAN if DEBOUNCE_CNT=1); else stay.
REQ-022 RELEASE, tick: all cols high -> count++, on DEBOUNCE_CNT go SCAN with key_held=0 and row advanced; any low col -> HELD, count reset.
REQ-023 A held key SHALL produce exactly one key_valid; no auto-repeat.
REQ-024 clear and accept in the same cycle: key_data SHALL become zero; key_code and key_valid unaffected.
REQ-025 Press-to-key_valid latency: DEBOUNCE_CNT ticks after first valid sample plus 1 cycle, plus 2 synchronizer cycles from pin.

Reset
REQ-026 rst_n low SHALL immediately force: state SCAN, row_n 4'b1110, key_code 0, key_valid 0, key_held 0, key_data 0, tick counter 0, debounce count 0, synchronizer flops 4'b1111.
REQ-027 Reset asserted mid-debounce or mid-hold SHALL discard the pending key; no key_valid after release of reset until a fresh full debounce.

Structure
REQ-028 Package keypad_pkg SHALL hold state encoding, KEY_ROWS=4, KEY_COLS=4, and the idle row_n value 4'b1110.
REQ-029 Tick divider SHALL be a sub-module tick_gen (parameter DIV, outputs tick); FSM, synchronizer and shift register stay in keypad_scan_unit.

Verification (bench: SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-030 Idle cols 4'b1111 for 64 cycles -> row_n cycles 1110,1101,1011,0111 every 4 cycles, key_valid never high.
REQ-031 Press row 2/col 1 (col_n=4'b1101 while row_n=1011) held 40 cycles -> one key_valid, key_code 4'h9, key_data 32'h00000009, key_held high until 3 ticks after release.
REQ-032 Press of 1 tick then bounce high -> no key_valid, scan resumes at row 3.
REQ-033 Two cols low together (col_n=4'b1100) -> no key_valid; sequence keys 1,2,3 -> key_data 32'h00000123.
REQ-034 clear coinciding with accept of key 4'h5 -> key_data 0, key_code 4'h5, key_valid pulses.
REQ-035 rst_n low during DEBOUNCE count 2 -> all outputs at reset values immediately; no key_valid after deassert while key stays held less than 3 ticks.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad scanner definitions: matrix geometry, FSM states and row/column helpers.
package keypad_pkg;

   localparam int KEY_ROWS = 4;
   localparam int KEY_COLS = 4;
   localparam int ROW_W = $clog2(KEY_ROWS);
   localparam logic [3:0] ROW_IDLE = 4'b1110;

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_HELD,
      ST_RELEASE
   } state_t;

   function automatic logic [3:0] row_drive(input logic [ROW_W-1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

   // Only meaningful when exactly one column is low; callers gate on that.
   function automatic logic [1:0] col_index(input logic [3:0] cols);
      logic [1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < KEY_COLS; i++) begin
         if (!cols[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: tick is high for one cycle out of every DIV cycles.
module tick_gen #(
   parameter int unsigned DIV = 1000
) (
   input  logic clk_src,
   input  logic rst_n,
   output logic tick
);

   localparam int unsigned W = $clog2(DIV);

   logic [W-1:0] cnt;

   assign tick = (cnt == W'(DIV - 1));

   always_ff @(posedge clk_src or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/keypad_scan_unit.sv
// 4x4 matrix keypad scanner with ghost rejection, press/release debounce and a key-code history register.
module keypad_scan_unit
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 1000,
   parameter int unsigned DEBOUNCE_CNT = 4,
   parameter int unsigned DATA_WIDTH   = 32
) (
   input  logic                  clk_src,
   input  logic                  rst_n,
   input  logic [3:0]            col_n,
   input  logic                  clear,
   output logic [3:0]            row_n,
   output logic [3:0]            key_code,
   output logic                  key_valid,
   output logic                  key_held,
   output logic [DATA_WIDTH-1:0] key_data
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT);

   state_t           state;
   logic             tick;
   logic [3:0]       sync1, sync2;
   logic [ROW_W-1:0] row_idx, row_nxt;
   logic [1:0]       col_lat, col_idx;
   logic [CW-1:0]    cnt, cnt_inc;
   logic             one_low, all_high, same_col, accept, release_done;

   tick_gen #(.DIV(SCAN_DIV)) u_tick (
      .clk_src (clk_src),
      .rst_n   (rst_n),
      .tick    (tick)
   );

   // Accept and release-complete are decoded once so both DEBOUNCE_CNT=1 shortcuts share one path.
   always_comb begin
      one_low      = ($countones(~sync2) == 1);
      all_high     = &sync2;
      col_idx      = col_index(sync2);
      same_col     = one_low && (col_idx == col_lat);
      cnt_inc      = cnt + CW'(1);
      row_nxt      = row_idx + ROW_W'(1);
      accept       = tick && ((state == ST_SCAN && one_low && DEBOUNCE_CNT == 1) ||
                              (state == ST_DEBOUNCE && same_col && cnt_inc == CNT_LAST));
      release_done = tick && all_high && ((state == ST_HELD && DEBOUNCE_CNT == 1) ||
                                          (state == ST_RELEASE && cnt_inc == CNT_LAST));
   end

   always_ff @(posedge clk_src or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_SCAN;
         sync1     <= '1;
         sync2     <= '1;
         row_idx   <= '0;
         row_n     <= ROW_IDLE;
         col_lat   <= '0;
         cnt       <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         key_data  <= '0;
      end else begin
         sync1     <= col_n;
         sync2     <= sync1;
         key_valid <= accept;

         if (clear) begin
            key_data <= '0;
         end else if (accept) begin
            key_data <= (key_data << 4) | DATA_WIDTH'({row_idx, col_idx});
         end

         if (accept) begin
            key_code <= {row_idx, col_idx};
            key_held <= 1'b1;
            cnt      <= '0;
            state    <= ST_HELD;
         end else if (release_done) begin
            key_held <= 1'b0;
            cnt      <= '0;
            row_idx  <= row_nxt;
            row_n    <= row_drive(row_nxt);
            state    <= ST_SCAN;
         end else if (tick) begin
            case (state)
               ST_SCAN: begin
                  if (one_low) begin
                     col_lat <= col_idx;
                     cnt     <= CW'(1);
                     state   <= ST_DEBOUNCE;
                  end else begin
                     row_idx <= row_nxt;
                     row_n   <= row_drive(row_nxt);
                  end
               end
               ST_DEBOUNCE: begin
                  if (same_col) begin
                     cnt <= cnt_inc;
                  end else begin
                     cnt     <= '0;
                     row_idx <= row_nxt;
                     row_n   <= row_drive(row_nxt);
                     state   <= ST_SCAN;
                  end
               end
               ST_HELD: begin
                  if (all_high) begin
                     cnt   <= CW'(1);
                     state <= ST_RELEASE;
                  end
               end
               ST_RELEASE: begin
                  if (all_high) begin
                     cnt <= cnt_inc;
                  end else begin
                     cnt   <= '0;
                     state <= ST_HELD;
                  end
               end
               default: state <= ST_SCAN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan_unit.sv
// Randomized and directed bench for keypad_scan_unit against a tick-level behavioural keypad model.
module tb_keypad_scan_unit;

   localparam int SD = 4;
   localparam int DC = 3;
   localparam int DW = 32;

   logic          clk_src = 1'b0;
   logic          rst_n;
   logic          clear;
   logic [3:0]    col_n, row_n, key_code;
   logic          key_valid, key_held;
   logic [DW-1:0] key_data;

   logic       press_en = 1'b0;
   int         press_row = 0, press_col = 0;
   logic       force_en = 1'b0;
   logic [3:0] force_val = 4'hF;

   int n_cmp = 0, n_bad = 0;
   int obs_pulses = 0;

   // Behavioural model state
   int         n, m_row, m_run, m_col, m_rel, accepts;
   logic       m_locked, m_valid;
   logic [3:0] m_code;
   logic [DW-1:0] m_data;
   logic [3:0] pa, pb;

   always #5 clk_src = ~clk_src;

   function automatic logic [3:0] pins(input logic [3:0] rows, input logic pe, input int pr,
                                       input int pc, input logic fe, input logic [3:0] fv);
      logic [3:0] v;
      v = 4'hF;
      if (fe) v = fv;
      else if (pe && rows[pr] == 1'b0) v[pc] = 1'b0;
      return v;
   endfunction

   assign col_n = pins(row_n, press_en, press_row, press_col, force_en, force_val);

   keypad_scan_unit #(
      .SCAN_DIV     (SD),
      .DEBOUNCE_CNT (DC),
      .DATA_WIDTH   (DW)
   ) dut (
      .clk_src   (clk_src),
      .rst_n     (rst_n),
      .col_n     (col_n),
      .clear     (clear),
      .row_n     (row_n),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held),
      .key_data  (key_data)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int low_idx(input logic [3:0] s);
      int cnt, idx;
      cnt = 0;
      idx = -1;
      for (int i = 0; i < 4; i++) begin
         if (!s[i]) begin
            cnt++;
            idx = i;
         end
      end
      return (cnt == 1) ? idx : -1;
   endfunction

   function automatic logic [3:0] model_rows();
      logic [3:0] t;
      t = 4'b0001 << m_row;
      return ~t;
   endfunction

   task automatic model_reset();
      n = 0; m_row = 0; m_run = 0; m_col = 0; m_rel = 0;
      m_locked = 1'b0; m_valid = 1'b0; m_code = 4'h0; m_data = '0;
      pa = 4'hF; pb = 4'hF;
   endtask

   task automatic check_outputs(input string pfx);
      check_eq({pfx, "row_n"}, 32'(row_n), 32'(model_rows()));
      check_eq({pfx, "key_valid"}, 32'(key_valid), 32'(m_valid));
      check_eq({pfx, "key_held"}, 32'(key_held), 32'(m_locked));
      check_eq({pfx, "key_code"}, 32'(key_code), 32'(m_code));
      check_eq({pfx, "key_data"}, key_data, m_data);
   endtask

   // One clock: the columns seen at a tick are the pins from two edges earlier.
   task automatic step();
      logic [3:0] cur, smp;
      int li;
      logic acc;
      cur = pins(model_rows(), press_en, press_row, press_col, force_en, force_val);
      smp = pb;
      pb = pa;
      pa = cur;
      @(posedge clk_src);
      n++;
      acc = 1'b0;
      if (n % SD == 0) begin
         li = low_idx(smp);
         if (!m_locked) begin
            if (li >= 0 && (m_run == 0 || li == m_col)) begin
               m_run++;
               m_col = li;
               if (m_run == DC) begin
                  acc = 1'b1; m_locked = 1'b1; m_rel = 0; m_run = 0;
               end
            end else begin
               m_run = 0;
               m_row = (m_row + 1) % 4;
            end
         end else if (smp == 4'hF) begin
            m_rel++;
            if (m_rel == DC) begin
               m_locked = 1'b0;
               m_row = (m_row + 1) % 4;
            end
         end else begin
            m_rel = 0;
         end
      end
      m_valid = acc;
      if (acc) begin
         m_code = 4'(m_row * 4 + m_col);
         accepts++;
      end
      if (clear) m_data = '0;
      else if (acc) m_data = {m_data[DW-5:0], m_code};
      @(negedge clk_src);
      if (key_valid === 1'b1) obs_pulses++;
      check_outputs("");
   endtask

   task automatic reset_dut();
      @(negedge clk_src);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("rst_");
      repeat (3) @(negedge clk_src);
      rst_n = 1'b1;
   endtask

   task automatic press_key(input int r, input int c, input int hold);
      int o0;
      o0 = obs_pulses;
      press_en = 1'b1; press_row = r; press_col = c;
      for (int i = 0; i < 200 && m_locked == 1'b0; i++) step();
      repeat (hold) step();
      press_en = 1'b0;
      for (int i = 0; i < 200 && m_locked == 1'b1; i++) step();
      repeat (2) step();
      check_eq("press_pulses", 32'(obs_pulses - o0), 32'd1);
      check_eq("held_after_release", 32'(key_held), 32'd0);
   endtask

   initial begin
      int o0, a0, dur;
      logic [3:0] gv;
      rst_n = 1'b1;
      clear = 1'b0;
      accepts = 0;
      model_reset();
      #2;
      reset_dut();

      // Idle scan
      o0 = obs_pulses;
      repeat (64) step();
      check_eq("idle_pulses", 32'(obs_pulses - o0), 32'd0);

      // Row 2 / col 1 held for 40 cycles
      o0 = obs_pulses;
      press_en = 1'b1; press_row = 2; press_col = 1;
      repeat (40) step();
      press_en = 1'b0;
      repeat (30) step();
      check_eq("k9_pulses", 32'(obs_pulses - o0), 32'd1);
      check_eq("k9_code", 32'(key_code), 32'h9);
      check_eq("k9_data", key_data, 32'h00000009);

      // One-tick bounce on row 2
      for (int i = 0; i < 100 && !(n % SD == 0 && m_row == 2 && !m_locked); i++) step();
      o0 = obs_pulses;
      press_en = 1'b1; press_row = 2; press_col = 0;
      repeat (4) step();
      press_en = 1'b0;
      repeat (4) step();
      check_eq("bounce_row", 32'(row_n), 32'h7);
      repeat (8) step();
      check_eq("bounce_pulses", 32'(obs_pulses - o0), 32'd0);

      // Ghosting, then keys 1,2,3
      o0 = obs_pulses;
      force_en = 1'b1; force_val = 4'b1100;
      repeat (40) step();
      force_en = 1'b0;
      check_eq("ghost_pulses", 32'(obs_pulses - o0), 32'd0);
      clear = 1'b1; step(); clear = 1'b0;
      press_key(0, 1, 8);
      press_key(0, 2, 8);
      press_key(0, 3, 8);
      check_eq("seq_data", key_data, 32'h00000123);

      // Clear coinciding with accept of key 5
      a0 = accepts;
      press_en = 1'b1; press_row = 1; press_col = 1;
      for (int i = 0; i < 200 && accepts == a0; i++) begin
         clear = ((n + 1) % SD == 0) && !m_locked && (m_run == DC - 1) && (low_idx(pb) == m_col);
         step();
      end
      clear = 1'b0;
      check_eq("clr_valid", 32'(key_valid), 32'd1);
      check_eq("clr_code", 32'(key_code), 32'h5);
      check_eq("clr_data", key_data, 32'h0);
      press_en = 1'b0;
      for (int i = 0; i < 200 && m_locked; i++) step();
      repeat (4) step();

      // Reset during debounce count 2
      press_en = 1'b1; press_row = 0; press_col = 1;
      for (int i = 0; i < 200 && m_run != 2; i++) step();
      check_eq("pre_reset_held", 32'(key_held), 32'd0);
      reset_dut();
      o0 = obs_pulses;
      repeat (9) step();
      press_en = 1'b0;
      repeat (21) step();
      check_eq("post_reset_pulses", 32'(obs_pulses - o0), 32'd0);

      // Random episodes
      for (int ep = 0; ep < 120; ep++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: begin
               press_en = 1'b1;
               press_row = $urandom_range(0, 3);
               press_col = $urandom_range(0, 3);
               dur = $urandom_range(1, 50);
               repeat (dur) begin
                  clear = ($urandom_range(0, 15) == 0);
                  step();
               end
               press_en = 1'b0;
               clear = 1'b0;
               dur = $urandom_range(0, 30);
               repeat (dur) step();
            end
            6: begin
               gv = 4'($urandom_range(0, 15));
               if (gv == 4'hF || low_idx(gv) >= 0) gv = 4'b0101;
               force_en = 1'b1; force_val = gv;
               dur = $urandom_range(10, 30);
               repeat (dur) step();
               force_en = 1'b0;
            end
            default: begin
               dur = $urandom_range(1, 20);
               repeat (dur) begin
                  clear = ($urandom_range(0, 7) == 0);
                  step();
               end
               clear = 1'b0;
            end
         endcase
      end
      repeat (40) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
